// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin byte scheduler feeding a UART transmitter.
// Owns the baud tick generator, picks one requester per transmission,
// hands the byte to the transmitter and watches for a stalled transfer.
module uart_tx_sched #(
  parameter int NUM_REQ   = 4,
  parameter int DIV_W     = 16,
  parameter int TMO_TICKS = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [DIV_W-1:0]           baud_div,
  output logic                       tx_clk,
  output logic                       tx_enable,
  output logic [7:0]                 tx_byte,
  input  logic                       tx_start,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] cur_src,
  output logic                       sched_busy,
  output logic                       tmo_err
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int TMO_W = $clog2(TMO_TICKS + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_XFER} state_t;

  state_t             r_state;
  logic [DIV_W-1:0]   r_baud_cnt;
  logic [TMO_W-1:0]   r_tick_cnt;
  logic [SRC_W-1:0]   r_ptr;
  logic [SRC_W-1:0]   r_cur_src;
  logic [7:0]         r_tx_byte;
  logic               r_tx_enable;
  logic               r_tmo_err;

  logic               w_div_small;
  logic               w_reload;
  logic               w_tick;
  logic               w_found;
  logic [SRC_W-1:0]   w_grant;
  logic [SRC_W-1:0]   w_idx;
  logic [7:0]         w_grant_byte;

  // Divisors of 0 and 1 both mean "tick every cycle". Reloading on
  // count >= div-1 also recovers when the divisor is lowered below the
  // current count.
  assign w_div_small = (baud_div <= DIV_W'(1));
  assign w_reload    = w_div_small || (r_baud_cnt >= (baud_div - DIV_W'(1)));
  assign w_tick      = !rst && (w_div_small || (r_baud_cnt == (baud_div - DIV_W'(1))));

  // Free-running baud counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baud_cnt <= '0;
    end else if (w_reload) begin
      r_baud_cnt <= '0;
    end else begin
      r_baud_cnt <= r_baud_cnt + DIV_W'(1);
    end
  end

  // Round-robin search: first valid requester above the last one served
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = SRC_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  // Byte lane of the granted requester
  always_comb begin
    w_grant_byte = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == SRC_W'(i)) begin
        w_grant_byte = req_data[8*i +: 8];
      end
    end
  end

  // Accept is offered only while idle; held low during reset
  assign req_ready = (!rst && (r_state == S_IDLE) && w_found)
                     ? (NUM_REQ'(1) << w_grant) : '0;

  // Scheduler FSM: grant, request start, wait for done or timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tx_enable <= 1'b0;
      r_tx_byte   <= 8'h00;
      r_cur_src   <= '0;
      r_ptr       <= SRC_W'(NUM_REQ - 1);
      r_tick_cnt  <= '0;
      r_tmo_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_tx_byte   <= w_grant_byte;
            r_cur_src   <= w_grant;
            r_tx_enable <= 1'b1;
            r_tick_cnt  <= '0;
            r_state     <= S_START;
          end
        end
        S_START: begin
          if (tx_start) begin
            r_tx_enable <= 1'b0;
            r_tick_cnt  <= '0;
            r_state     <= S_XFER;
          end
        end
        S_XFER: begin
          // A done arriving on the final tick still counts as success
          if (tx_done) begin
            r_ptr   <= r_cur_src;
            r_state <= S_IDLE;
          end else if (w_tick) begin
            if (r_tick_cnt == TMO_W'(TMO_TICKS - 1)) begin
              r_tmo_err <= 1'b1;
              r_ptr     <= r_cur_src;
              r_state   <= S_IDLE;
            end else begin
              r_tick_cnt <= r_tick_cnt + TMO_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_clk     = w_tick;
  assign tx_enable  = r_tx_enable;
  assign tx_byte    = r_tx_byte;
  assign cur_src    = r_cur_src;
  assign sched_busy = (r_state != S_IDLE);
  assign tmo_err    = r_tmo_err;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed and randomized checks of uart_tx_sched against
// a round-robin / baud-period reference model held in the bench.
module tb_uart_tx_sched;

  localparam int NR  = 4;
  localparam int DW  = 16;
  localparam int TMO = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic [DW-1:0]   baud_div = 16'd4;
  logic            tx_clk;
  logic            tx_enable;
  logic [7:0]      tx_byte;
  logic            tx_start = 1'b0;
  logic            tx_done = 1'b0;
  logic [1:0]      cur_src;
  logic            sched_busy;
  logic            tmo_err;

  int   n_total = 0;
  int   n_pass  = 0;
  int   m_rel_cyc;
  int   m_div;
  int   m_ptr;
  logic m_tmo;

  uart_tx_sched #(.NUM_REQ(NR), .DIV_W(DW), .TMO_TICKS(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .baud_div(baud_div), .tx_clk(tx_clk),
    .tx_enable(tx_enable), .tx_byte(tx_byte), .tx_start(tx_start),
    .tx_done(tx_done), .cur_src(cur_src), .sched_busy(sched_busy),
    .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    m_rel_cyc++;
  endtask

  task automatic settle();
    #1;
  endtask

  // Expected baud tick: one cycle in every div, on the last cycle of each period
  function automatic logic exp_tick();
    if (m_div <= 1) return 1'b1;
    return ((m_rel_cyc % m_div) == (m_div - 1));
  endfunction

  // Next requester after 'last' (wrapping) that has a byte available
  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (last + k) % NR;
      if (((int'(v) >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  task automatic do_reset(input int div);
    @(negedge clk);
    rst = 1'b1;
    baud_div = 16'(div);
    req_valid = 4'hF;
    tx_start = 1'b0;
    tx_done = 1'b0;
    settle();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_tx_enable", 32'(tx_enable), 32'h0);
    chk("rst_tx_byte", 32'(tx_byte), 32'h0);
    chk("rst_cur_src", 32'(cur_src), 32'h0);
    chk("rst_busy", 32'(sched_busy), 32'h0);
    chk("rst_tmo_err", 32'(tmo_err), 32'h0);
    chk("rst_tx_clk", 32'(tx_clk), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    m_rel_cyc = 0;
    m_div = div;
    m_ptr = NR - 1;
    m_tmo = 1'b0;
  endtask

  // One full transmission. Entered in an idle cycle just after a negedge.
  task automatic xfer(input logic [NR-1:0] v, input logic [31:0] d,
                      input int sdly, input int dticks);
    int         g;
    int         ticks;
    logic       t;
    logic [7:0] eb;
    bit         fin;
    req_valid = v;
    req_data = d;
    settle();
    g = rr_pick(v, m_ptr);
    eb = 8'(d >> (8 * g));
    chk("idle_ready", 32'(req_ready), 32'(1) << g);
    chk("idle_busy", 32'(sched_busy), 32'h0);
    step();
    req_valid = 4'($urandom);
    req_data = $urandom;
    settle();
    chk("start_ready", 32'(req_ready), 32'h0);
    chk("start_enable", 32'(tx_enable), 32'h1);
    chk("start_byte", 32'(tx_byte), 32'(eb));
    chk("start_src", 32'(cur_src), 32'(g));
    chk("start_busy", 32'(sched_busy), 32'h1);
    for (int i = 0; i < sdly; i++) begin
      step();
      tx_done = (i == 0);
      settle();
      chk("start_hold_enable", 32'(tx_enable), 32'h1);
      chk("start_hold_byte", 32'(tx_byte), 32'(eb));
    end
    step();
    tx_done = 1'b0;
    tx_start = 1'b1;
    settle();
    chk("start_wait_enable", 32'(tx_enable), 32'h1);
    step();
    tx_start = 1'b0;
    ticks = 0;
    fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      settle();
      t = exp_tick();
      chk("xfer_tx_clk", 32'(tx_clk), 32'(t));
      chk("xfer_enable", 32'(tx_enable), 32'h0);
      chk("xfer_byte", 32'(tx_byte), 32'(eb));
      chk("xfer_ready", 32'(req_ready), 32'h0);
      chk("xfer_busy", 32'(sched_busy), 32'h1);
      if (t) ticks++;
      if (t && ticks == dticks) begin
        tx_done = 1'b1;
        fin = 1'b1;
      end else if (t && ticks == TMO) begin
        m_tmo = 1'b1;
        fin = 1'b1;
      end
      step();
      tx_done = 1'b0;
    end
    if (!fin) chk("xfer_bound", 32'h0, 32'h1);
    m_ptr = g;
    settle();
    chk("end_busy", 32'(sched_busy), 32'h0);
    chk("end_tmo_err", 32'(tmo_err), 32'(m_tmo));
  endtask

  initial begin
    logic [31:0] d;

    // Baud generator, divisor 4, no requests
    do_reset(4);
    for (int i = 0; i < 20; i++) begin
      settle();
      chk("baud4_tx_clk", 32'(tx_clk), 32'(exp_tick()));
      chk("baud4_busy", 32'(sched_busy), 32'h0);
      step();
    end

    // Divisor 0: tick every cycle
    do_reset(0);
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("baud0_tx_clk", 32'(tx_clk), 32'(exp_tick()));
      step();
    end

    // Divisor lowered from 8 to 3 while the count is already past 3
    do_reset(8);
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("baud8_tx_clk", 32'(tx_clk), 32'(exp_tick()));
      step();
    end
    baud_div = 16'd3;
    settle();
    chk("baud_lower_tx_clk", 32'(tx_clk), 32'h0);
    step();
    for (int i = 0; i < 9; i++) begin
      settle();
      chk("baud3_tx_clk", 32'(tx_clk), 32'(((m_rel_cyc - 7) % 3) == 2));
      step();
    end

    // All four requesters: A0,A1,A2,A3,A0
    do_reset(2);
    for (int i = 0; i < 5; i++) begin
      xfer(4'hF, 32'hA3A2A1A0, int'($urandom_range(0, 3)), 10);
    end

    // Only requester 2
    d = $urandom;
    d[23:16] = 8'h5C;
    xfer(4'b0100, d, 2, 10);

    // Done on the same tick as the timeout: done wins
    xfer(4'hF, $urandom, 1, TMO);

    // Done withheld: timeout, then the next requester is served
    xfer(4'hF, $urandom, 0, 1000);
    xfer(4'hF, $urandom, 1, 5);

    // Randomized traffic
    for (int i = 0; i < 12; i++) begin
      xfer(4'($urandom_range(1, 15)), $urandom, int'($urandom_range(0, 3)),
           int'($urandom_range(1, 14)));
    end

    // Reset in the middle of a transfer
    req_valid = 4'b0010;
    req_data = $urandom;
    settle();
    step();
    tx_start = 1'b1;
    settle();
    step();
    tx_start = 1'b0;
    step();
    step();
    do_reset(2);
    req_valid = 4'hF;
    settle();
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    xfer(4'hF, 32'h44332211, 0, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte requesters (2..8).
REQ-002 SHALL have parameter DIV_W, default 16, width of baud divisor.
REQ-003 SHALL have parameter TMO_TICKS, default 12, baud ticks allowed in XFER before timeout.
REQ-004 SHALL have port clk  in  1  system clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  NUM_REQ  per-requester byte available.
REQ-007 SHALL have port req_data  in  8*NUM_REQ  byte i at bits [8i+7:8i].
REQ-008 SHALL have port req_ready  out  NUM_REQ  one-hot accept; transfer when valid&ready same cycle.
REQ-009 SHALL have port baud_div  in  DIV_W  clk cycles per baud tick.
REQ-010 SHALL have port tx_clk  out  1  one-cycle baud tick to transmitter.
REQ-011 SHALL have port tx_enable  out  1  start request to transmitter.
REQ-012 SHALL have port tx_byte  out  8  byte to transmitter, held stable START through XFER.
REQ-013 SHALL have port tx_start  in  1  transmitter start-accepted pulse.
REQ-014 SHALL have port tx_done  in  1  transmitter stop-bit-complete pulse.
REQ-015 SHALL have port cur_src  out  $clog2(NUM_REQ)  index of requester being served.
REQ-016 SHALL have port sched_busy  out  1  high whenever state != IDLE.
REQ-017 SHALL have port tmo_err  out  1  sticky timeout flag.

Function
REQ-018 SHALL run a free-running baud counter 0..baud_div-1, tx_clk=1 for the cycle counter==baud_div-1; baud_div 0 or 1 -> tx_clk every cycle.
REQ-019 SHALL reload baud counter to 0 when it reaches baud_div-1 or when count >= baud_div (divisor lowered on the fly).
REQ-020 SHALL implement FSM states IDLE, START, XFER.
REQ-021 IDLE: if any req_valid, req_ready SHALL be combinationally one-hot on the first valid index searching upward from ptr+1 mod NUM_REQ; else req_ready=0.
REQ-022 On IDLE handshake, tx_byte<=req_data[grant], cur_src<=grant, state<=START, next cycle.
REQ-023 req_ready SHALL be 0 in START and XFER; at most one byte accepted per transmission.
REQ-024 START: tx_enable=1 (registered, from first START cycle) until tx_start sampled high; then tx_enable<=0, state<=XFER.
REQ-025 XFER: on tx_done, state<=IDLE, ptr<=cur_src; earliest next grant one cycle after tx_done.
REQ-026 XFER: count tx_clk ticks; if count reaches TMO_TICKS without tx_done, SHALL set tmo_err=1, update ptr, return to IDLE.
REQ-027 tx_done and timeout in same cycle: tx_done wins, tmo_err unchanged.
REQ-028 tx_done or tx_start outside its waiting state SHALL be ignored.
REQ-029 Requester deasserting req_valid before grant SHALL simply lose the arbitration; no state change.
REQ-030 tmo_err SHALL clear only on rst.

Reset
REQ-031 On rst: state=IDLE, req_ready=0, tx_enable=0, tx_byte=8'h00, cur_src=0, tx_clk=0, baud count=0, tick count=0, tmo_err=0, ptr=NUM_REQ-1 (requester 0 served first).
REQ-032 rst mid-START/XFER SHALL abort immediately; pending byte dropped, no req_ready after release until IDLE arbitration.

Verification
REQ-033 baud_div=4, no requests -> tx_clk high every 4th cycle, continuous; baud_div=0 -> every cycle.
REQ-034 req_valid=4'b1111, data 8'hA0..8'hA3, transmitter model done after 10 ticks -> tx_byte sequence A0,A1,A2,A3,A0, cur_src 0,1,2,3,0.
REQ-035 Only req 2 valid (8'h5C) -> req_ready=4'b0100 one cycle, tx_enable high until tx_start, tx_byte=8'h5C held to tx_done.
REQ-036 tx_done withheld, TMO_TICKS=12 -> tmo_err=1 after 12th tick in XFER, state IDLE, next requester granted.
REQ-037 rst pulsed during XFER -> all outputs to reset values same cycle; after release req 0 granted first.
REQ-038 tx_done and 12th tick same cycle -> tmo_err stays 0, normal return to IDLE.
